// File: rtl/ifetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_unit_pkg
// Shared definitions for the instruction fetch unit:
//   - fetch_state_t : FSM state encoding (IDLE, FETCH, EXEC)
//   - OP_JMP/OP_BRZ/OP_BRN : 7-bit opcodes (IR[15:9]) of the control-flow ops
//   - TIMEOUT_LIMIT : wait-counter value that aborts a fetch when the
//                     FETCH_TIMEOUT_EN build option is enabled
//   - branch_offset_of() : builds the sign-extended 6-bit branch offset
// ---------------------------------------------------------------------------
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_t;

  localparam logic [6:0] OP_JMP = 7'b1110000;
  localparam logic [6:0] OP_BRZ = 7'b1100000;
  localparam logic [6:0] OP_BRN = 7'b1100001;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  // The branch offset is split across the destination and B-register
  // fields; the upper field's MSB is the sign bit of the 6-bit value.
  function automatic logic [15:0] branch_offset_of(input logic [2:0] hi_field,
                                                   input logic [2:0] lo_field);
    return {{10{hi_field[2]}}, hi_field, lo_field};
  endfunction

endpackage

// File: rtl/ifetch_unit_ir_decode.sv
// ---------------------------------------------------------------------------
// ir_decode
// Purely combinational decode of the instruction register.
// Ports:
//   IR            in  16  instruction register contents
//   ir_valid      in   1  high only in the execute cycle; gates PL/JB/BC
//   PL, JB, BC    out  1  PC-load, jump/branch, branch-condition controls
//   branch_offset out 16  sign-extended {IR[8:6], IR[2:0]}
//   DA, AA, BA    out  3  register fields IR[8:6], IR[5:3], IR[2:0]
// The register fields and branch offset follow IR regardless of ir_valid so
// downstream logic can set up operands early; only the PC controls are gated.
// ---------------------------------------------------------------------------
module ir_decode
  import ifetch_unit_pkg::*;
(
  input  logic [15:0] IR,
  input  logic        ir_valid,
  output logic        PL,
  output logic        JB,
  output logic        BC,
  output logic [15:0] branch_offset,
  output logic [2:0]  DA,
  output logic [2:0]  AA,
  output logic [2:0]  BA
);

  logic [6:0] opcode;

  assign opcode = IR[15:9];

  // Control-flow decode. Everything defaults to 0 so that a stale IR held
  // during FETCH/IDLE can never load the PC.
  always_comb begin
    PL = 1'b0;
    JB = 1'b0;
    BC = 1'b0;
    if (ir_valid) begin
      case (opcode)
        OP_JMP: begin
          PL = 1'b1;
          JB = 1'b1;
        end
        OP_BRZ: begin
          PL = 1'b1;
        end
        OP_BRN: begin
          PL = 1'b1;
          BC = 1'b1;
        end
        default: begin
          PL = 1'b0;
        end
      endcase
    end
  end

  // Field extraction and offset formation are ungated.
  assign DA            = IR[8:6];
  assign AA            = IR[5:3];
  assign BA            = IR[2:0];
  assign branch_offset = branch_offset_of(IR[8:6], IR[2:0]);

endmodule

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch unit: IDLE -> FETCH -> EXEC -> FETCH ... sequencer that
// reads one instruction word per fetch, holds it in IR and pulses pc_advance
// during the single execute cycle.
// Ports:
//   clock, reset        in   1  rising-edge clock; synchronous active-high reset
//   PC                  in  16  program counter, sampled when a fetch starts
//   imem_req            out  1  high for every FETCH cycle
//   imem_addr           out 16  address latched at fetch start, held to ack
//   imem_ack            in   1  memory data valid (ignored outside FETCH)
//   imem_rdata          in  16  instruction word
//   IR                  out 16  instruction register
//   ir_valid            out  1  high in the EXEC cycle
//   pc_advance          out  1  one-cycle pulse in EXEC
//   PL, JB, BC          out  1  decoded PC controls (EXEC only)
//   branch_offset       out 16  sign-extended branch offset
//   DA, AA, BA          out  3  register fields
//   fetch_err           out  1  sticky timeout flag (FETCH_TIMEOUT_EN only)
// Build option: define FETCH_TIMEOUT_EN to abort a fetch after 255 cycles
// without ack; IR is then loaded with 16'h0000 and fetch_err is set.
// ---------------------------------------------------------------------------
module ifetch_unit
  import ifetch_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] PC,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] IR,
  output logic        ir_valid,
  output logic        pc_advance,
  output logic        PL,
  output logic        JB,
  output logic        BC,
  output logic [15:0] branch_offset,
  output logic [2:0]  DA,
  output logic [2:0]  AA,
  output logic [2:0]  BA
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic        fetch_err
`endif
);

  fetch_state_t state;
  fetch_state_t next_state;

  logic        latch_addr;
  logic        load_ir;
  logic [15:0] ir_load_val;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_count;
  logic       timeout_hit;
`endif

  // State register. Reset overrides everything, including an ack that
  // arrives in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode. latch_addr marks every transition into
  // FETCH (from IDLE or EXEC) so the address is captured exactly once per
  // request and then held regardless of PC activity.
  always_comb begin
    next_state  = state;
    imem_req    = 1'b0;
    ir_valid    = 1'b0;
    pc_advance  = 1'b0;
    latch_addr  = 1'b0;
    load_ir     = 1'b0;
    ir_load_val = imem_rdata;
`ifdef FETCH_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        next_state = FETCH;
        latch_addr = 1'b1;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          next_state = EXEC;
          load_ir    = 1'b1;
        end
`ifdef FETCH_TIMEOUT_EN
        // The count lags by one cycle, so LIMIT-1 here means this is the
        // LIMIT-th ackless FETCH cycle.
        else if (wait_count == (TIMEOUT_LIMIT - 8'd1)) begin
          next_state  = EXEC;
          load_ir     = 1'b1;
          ir_load_val = 16'h0000;
          timeout_hit = 1'b1;
        end
`endif
      end
      EXEC: begin
        ir_valid   = 1'b1;
        pc_advance = 1'b1;
        next_state = FETCH;
        latch_addr = 1'b1;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Address latch and instruction register.
  always_ff @(posedge clock) begin
    if (reset) begin
      imem_addr <= 16'h0000;
      IR        <= 16'h0000;
    end else begin
      if (latch_addr) begin
        imem_addr <= PC;
      end
      if (load_ir) begin
        IR <= ir_load_val;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Wait counter: cleared whenever a new fetch begins, counts ackless
  // FETCH cycles. fetch_err is sticky until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_count <= 8'd0;
      fetch_err  <= 1'b0;
    end else begin
      if (latch_addr) begin
        wait_count <= 8'd0;
      end else if ((state == FETCH) && !imem_ack) begin
        wait_count <= wait_count + 8'd1;
      end
      if (timeout_hit) begin
        fetch_err <= 1'b1;
      end
    end
  end
`endif

  // Decode of IR into PC controls and register fields.
  ir_decode u_ir_decode (
    .IR            (IR),
    .ir_valid      (ir_valid),
    .PL            (PL),
    .JB            (JB),
    .BC            (BC),
    .branch_offset (branch_offset),
    .DA            (DA),
    .AA            (AA),
    .BA            (BA)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
// Self-checking bench for ifetch_unit. A directed section pins known
// instruction words and reset/ack corner cases with literal expectations,
// then a randomized section drives reset, PC, ack and rdata. A reference
// model, described in terms of "cycles since reset" and "cycles since the
// last accepted word", predicts every output each cycle.
// Define FETCH_TIMEOUT_EN to also cover the timeout feature.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] PC;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] IR;
  logic        ir_valid;
  logic        pc_advance;
  logic        PL;
  logic        JB;
  logic        BC;
  logic [15:0] branch_offset;
  logic [2:0]  DA;
  logic [2:0]  AA;
  logic [2:0]  BA;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_err;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit          m_known       = 1'b0;
  int          m_since_reset = 0;
  int          m_since_ack   = 2;
  logic [15:0] m_ir          = 16'h0000;
  logic [15:0] m_addr        = 16'h0000;
`ifdef FETCH_TIMEOUT_EN
  int          m_wait        = 0;
  logic        m_err         = 1'b0;
`endif

  ifetch_unit dut (
    .clock         (clock),
    .reset         (reset),
    .PC            (PC),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .IR            (IR),
    .ir_valid      (ir_valid),
    .pc_advance    (pc_advance),
    .PL            (PL),
    .JB            (JB),
    .BC            (BC),
    .branch_offset (branch_offset),
    .DA            (DA),
    .AA            (AA),
    .BA            (BA)
`ifdef FETCH_TIMEOUT_EN
    ,
    .fetch_err     (fetch_err)
`endif
  );

  always #5 clock = ~clock;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives the inputs for the cycle that starts at the next rising edge.
  task automatic applyStimulus(input logic r, input logic [15:0] pc,
                               input logic ack, input logic [15:0] rdata);
    @(posedge clock);
    #2;
    reset      = r;
    PC         = pc;
    imem_ack   = ack;
    imem_rdata = rdata;
  endtask

  // One complete fetch starting in a FETCH cycle: 'waits' ackless cycles,
  // the ack cycle, then the execute cycle (where a stray ack is offered).
  task automatic fetchWord(input logic [15:0] exp_addr, input logic [15:0] pc_drive,
                           input logic [15:0] word, input int waits,
                           input logic [15:0] pc_after);
    for (int i = 0; i < waits; i++) begin
      applyStimulus(1'b0, pc_drive, 1'b0, 16'hDEAD);
      checkOutput("wait_req", 16'(imem_req), 16'h0001);
      checkOutput("wait_addr", imem_addr, exp_addr);
      checkOutput("wait_ir_valid", 16'(ir_valid), 16'h0000);
      checkOutput("wait_pl", 16'(PL), 16'h0000);
    end
    applyStimulus(1'b0, pc_drive, 1'b1, word);
    checkOutput("ack_req", 16'(imem_req), 16'h0001);
    checkOutput("ack_addr", imem_addr, exp_addr);
    applyStimulus(1'b0, pc_after, 1'b1, 16'hFFFF);
    checkOutput("exec_ir", IR, word);
    checkOutput("exec_ir_valid", 16'(ir_valid), 16'h0001);
    checkOutput("exec_pc_advance", 16'(pc_advance), 16'h0001);
    checkOutput("exec_req", 16'(imem_req), 16'h0000);
  endtask

  // Reference model and per-cycle compare. Outputs are compared on the
  // falling edge; the model then advances using the inputs that will be
  // sampled at the coming rising edge.
  initial begin : compare_proc
    bit          exec_now;
    bit          requesting;
    logic [6:0]  op;
    int          off;
    forever begin
      @(negedge clock);
      exec_now   = (m_since_ack == 1);
      requesting = (m_since_reset > 0) && !exec_now;
      if (m_known) begin
        op  = m_ir[15:9];
        off = int'({m_ir[8:6], m_ir[2:0]});
        if (off >= 32) off = off - 64;
        checkOutput("model_imem_req", 16'(imem_req), 16'(requesting));
        if (requesting) checkOutput("model_imem_addr", imem_addr, m_addr);
        checkOutput("model_ir", IR, m_ir);
        checkOutput("model_ir_valid", 16'(ir_valid), 16'(exec_now));
        checkOutput("model_pc_advance", 16'(pc_advance), 16'(exec_now));
        checkOutput("model_pl", 16'(PL),
                    16'(exec_now && (op == 7'h70 || op == 7'h60 || op == 7'h61)));
        checkOutput("model_jb", 16'(JB), 16'(exec_now && op == 7'h70));
        checkOutput("model_bc", 16'(BC), 16'(exec_now && op == 7'h61));
        checkOutput("model_offset", branch_offset, 16'(off));
        checkOutput("model_fields", {7'd0, DA, AA, BA}, {7'd0, m_ir[8:0]});
`ifdef FETCH_TIMEOUT_EN
        checkOutput("model_fetch_err", 16'(fetch_err), 16'(m_err));
`endif
      end
      if (reset) begin
        m_known       = 1'b1;
        m_since_reset = 0;
        m_since_ack   = 2;
        m_ir          = 16'h0000;
        m_addr        = 16'h0000;
`ifdef FETCH_TIMEOUT_EN
        m_wait        = 0;
        m_err         = 1'b0;
`endif
      end else if (m_known) begin
        if (!requesting) begin
          m_addr = PC;
`ifdef FETCH_TIMEOUT_EN
          m_wait = 0;
`endif
        end
        if (requesting && imem_ack) begin
          m_ir        = imem_rdata;
          m_since_ack = 1;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (requesting && m_wait == 254) begin
          m_ir        = 16'h0000;
          m_err       = 1'b1;
          m_since_ack = 1;
        end else if (requesting) begin
          m_wait++;
          if (m_since_ack < 1000) m_since_ack++;
        end
`endif
        else if (m_since_ack < 1000) begin
          m_since_ack++;
        end
        if (m_since_reset < 1000) m_since_reset++;
      end
    end
  end

  // Stimulus: directed corner cases, then randomized traffic.
  initial begin : drive_proc
    logic [6:0] op_pick;
    reset      = 1'b1;
    PC         = 16'h0000;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;

    applyStimulus(1'b1, 16'h0000, 1'b0, 16'h0000);
    applyStimulus(1'b1, 16'h0000, 1'b1, 16'h7777);
    checkOutput("rst_req", 16'(imem_req), 16'h0000);
    checkOutput("rst_addr", imem_addr, 16'h0000);
    checkOutput("rst_ir", IR, 16'h0000);
    checkOutput("rst_ir_valid", 16'(ir_valid), 16'h0000);
    checkOutput("rst_pc_advance", 16'(pc_advance), 16'h0000);

    applyStimulus(1'b0, 16'h0010, 1'b0, 16'h0000);
    checkOutput("idle_req", 16'(imem_req), 16'h0000);
    checkOutput("idle_ir_after_rst_ack", IR, 16'h0000);

    fetchWord(16'h0010, 16'h0010, 16'h1234, 1, 16'h0100);
    checkOutput("plain_pl", 16'(PL), 16'h0000);

    fetchWord(16'h0100, 16'h0100, 16'hE000, 0, 16'h0102);
    checkOutput("jmp_pljbbc", {13'd0, PL, JB, BC}, 16'h0006);

    fetchWord(16'h0102, 16'h0102, 16'hC1C6, 2, 16'h0104);
    checkOutput("brz_pljbbc", {13'd0, PL, JB, BC}, 16'h0004);
    checkOutput("brz_offset", branch_offset, 16'hFFFE);
    checkOutput("brz_da_ba", {10'd0, DA, BA}, 16'h003E);

    fetchWord(16'h0104, 16'h0104, 16'hC205, 0, 16'h0020);
    checkOutput("brn_pljbbc", {13'd0, PL, JB, BC}, 16'h0005);
    checkOutput("brn_offset", branch_offset, 16'h0005);

    fetchWord(16'h0020, 16'h0030, 16'h5A5A, 3, 16'h0040);
    checkOutput("nonctl_pl", 16'(PL), 16'h0000);

    applyStimulus(1'b1, 16'h0040, 1'b1, 16'hBEEF);
    applyStimulus(1'b0, 16'h0050, 1'b0, 16'h0000);
    checkOutput("rstack_ir", IR, 16'h0000);
    checkOutput("rstack_req", 16'(imem_req), 16'h0000);
    checkOutput("rstack_pc_advance", 16'(pc_advance), 16'h0000);
    applyStimulus(1'b0, 16'h0050, 1'b0, 16'h0000);
    checkOutput("rstack_refetch_req", 16'(imem_req), 16'h0001);
    checkOutput("rstack_refetch_addr", imem_addr, 16'h0050);
    checkOutput("rstack_no_advance", 16'(pc_advance), 16'h0000);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       op_pick = 7'b1110000;
        1:       op_pick = 7'b1100000;
        2:       op_pick = 7'b1100001;
        default: op_pick = 7'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 99) < 2), 16'($urandom),
                    ($urandom_range(0, 99) < 35), {op_pick, 9'($urandom)});
    end

`ifdef FETCH_TIMEOUT_EN
    applyStimulus(1'b1, 16'h0200, 1'b0, 16'h0000);
    applyStimulus(1'b0, 16'h0200, 1'b0, 16'h0000);
    for (int i = 0; i < 255; i++) begin
      applyStimulus(1'b0, 16'h0200, 1'b0, 16'h0000);
    end
    checkOutput("to_last_wait_err", 16'(fetch_err), 16'h0000);
    checkOutput("to_last_wait_req", 16'(imem_req), 16'h0001);
    applyStimulus(1'b0, 16'h0200, 1'b0, 16'h0000);
    checkOutput("to_exec_err", 16'(fetch_err), 16'h0001);
    checkOutput("to_exec_ir", IR, 16'h0000);
    checkOutput("to_exec_valid", 16'(ir_valid), 16'h0001);
    applyStimulus(1'b0, 16'h0200, 1'b0, 16'h0000);
    checkOutput("to_refetch_req", 16'(imem_req), 16'h0001);
    checkOutput("to_sticky_err", 16'(fetch_err), 16'h0001);
`endif

    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
